// File: rtl/exposure_timer_ctrl.sv
// Exposure setting register (clamped, key/load adjustable) plus a shutter timer FSM.
// Optional key auto-repeat is enabled by defining EXP_AUTO_REPEAT_EN.
module exposure_timer_ctrl #(
   parameter int W               = 5,
   parameter int EXP_MIN         = 2,
   parameter int EXP_MAX         = 30,
   parameter int EXP_DEFAULT     = 15,
   parameter int CLKS_PER_MS     = 1,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 100
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Exp_Increase,
   input  logic         Exp_Decrease,
   input  logic         Exp_Load,
   input  logic [W-1:0] Exp_Load_Value,
   input  logic         Start,
   output logic [W-1:0] Exp_Time,
   output logic         Shutter_Open,
   output logic         Busy,
   output logic         Done
);

   localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [W-1:0]  T_MIN      = W'(EXP_MIN);
   localparam logic [W-1:0]  T_MAX      = W'(EXP_MAX);
   localparam logic [W-1:0]  T_DEF      = W'(EXP_DEFAULT);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_MS - 1);

   if (EXP_MIN < 1 || EXP_MAX >= (1 << W) || EXP_MIN > EXP_MAX ||
       EXP_DEFAULT < EXP_MIN || EXP_DEFAULT > EXP_MAX || CLKS_PER_MS < 1 ||
       REPEAT_DELAY_MS < 1 || REPEAT_RATE_MS < 1) begin : g_param_check
      $error("exposure_timer_ctrl: illegal parameter set");
   end

   typedef enum logic [1:0] {S_IDLE, S_EXPOSE, S_DONE} state_t;

   state_t        state;
   logic [W-1:0]  remaining;
   logic [PW-1:0] presc;
   logic          inc_prev;
   logic          dec_prev;
   logic          inc_edge;
   logic          dec_edge;
   logic          up_req;
   logic          dn_req;
   logic [W-1:0]  load_clamped;

   assign inc_edge = Exp_Increase & ~inc_prev;
   assign dec_edge = Exp_Decrease & ~dec_prev;

   always_comb begin
      load_clamped = Exp_Load_Value;
      if (Exp_Load_Value < T_MIN)
         load_clamped = T_MIN;
      else if (Exp_Load_Value > T_MAX)
         load_clamped = T_MAX;
   end

`ifdef EXP_AUTO_REPEAT_EN
   localparam int HMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
   localparam int HW   = $clog2(HMAX + 1);

   logic [PW-1:0] hold_presc;
   logic [HW-1:0] hold_ms;
   logic [HW-1:0] hold_target;
   logic          repeating;
   logic          held;
   logic          rep_step;

   // Edge cycles count as "not held" so the hold timer restarts at each press.
   assign held = (state == S_IDLE) &&
                 ((Exp_Increase & inc_prev & ~Exp_Decrease) |
                  (Exp_Decrease & dec_prev & ~Exp_Increase));
   assign hold_target = repeating ? HW'(REPEAT_RATE_MS) : HW'(REPEAT_DELAY_MS);
   assign rep_step    = held && (hold_presc == PRESC_LAST) && (hold_ms + 1'b1 == hold_target);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         hold_presc <= '0;
         hold_ms    <= '0;
         repeating  <= 1'b0;
      end else if (!held) begin
         hold_presc <= '0;
         hold_ms    <= '0;
         repeating  <= 1'b0;
      end else if (hold_presc == PRESC_LAST) begin
         hold_presc <= '0;
         if (rep_step) begin
            hold_ms   <= '0;
            repeating <= 1'b1;
         end else begin
            hold_ms <= hold_ms + 1'b1;
         end
      end else begin
         hold_presc <= hold_presc + 1'b1;
      end
   end

   assign up_req = inc_edge | (rep_step & Exp_Increase);
   assign dn_req = dec_edge | (rep_step & Exp_Decrease);
`else
   assign up_req = inc_edge;
   assign dn_req = dec_edge;
`endif

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state        <= S_IDLE;
         Exp_Time     <= T_DEF;
         remaining    <= '0;
         presc        <= '0;
         Shutter_Open <= 1'b0;
         Busy         <= 1'b0;
         Done         <= 1'b0;
         inc_prev     <= 1'b1;
         dec_prev     <= 1'b1;
      end else begin
         inc_prev <= Exp_Increase;
         dec_prev <= Exp_Decrease;
         case (state)
            S_IDLE: begin
               if (Start) begin
                  remaining    <= Exp_Time;
                  presc        <= '0;
                  state        <= S_EXPOSE;
                  Shutter_Open <= 1'b1;
                  Busy         <= 1'b1;
               end else if (Exp_Load) begin
                  Exp_Time <= load_clamped;
               end else if (up_req && !dn_req) begin
                  if (Exp_Time < T_MAX)
                     Exp_Time <= Exp_Time + 1'b1;
               end else if (dn_req && !up_req) begin
                  if (Exp_Time > T_MIN)
                     Exp_Time <= Exp_Time - 1'b1;
               end
            end
            S_EXPOSE: begin
               if (presc == PRESC_LAST) begin
                  presc     <= '0;
                  remaining <= remaining - 1'b1;
                  if (remaining == W'(1)) begin
                     state        <= S_DONE;
                     Shutter_Open <= 1'b0;
                     Done         <= 1'b1;
                  end
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            S_DONE: begin
               Done  <= 1'b0;
               Busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state        <= S_IDLE;
               Shutter_Open <= 1'b0;
               Busy         <= 1'b0;
               Done         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exposure_timer_ctrl.sv
// Randomised and directed bench for exposure_timer_ctrl against a timestamp-based model.
module tb_exposure_timer_ctrl;

   localparam int W    = 5;
   localparam int MINV = 2;
   localparam int MAXV = 30;
   localparam int DEFV = 15;
   localparam int CPM  = 4;
   localparam int RD   = 5;
   localparam int RR   = 2;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         inc   = 1'b0;
   logic         dec   = 1'b0;
   logic         load  = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] lv    = '0;
   logic [W-1:0] exp_time;
   logic         shutter;
   logic         busy;
   logic         done;

   int unsigned total = 0;
   int unsigned bad   = 0;
   bit          checking = 1'b0;

   always #5 clk = ~clk;

   exposure_timer_ctrl #(
      .W(W), .EXP_MIN(MINV), .EXP_MAX(MAXV), .EXP_DEFAULT(DEFV),
      .CLKS_PER_MS(CPM), .REPEAT_DELAY_MS(RD), .REPEAT_RATE_MS(RR)
   ) dut (
      .Clk(clk), .Reset(rst_n), .Exp_Increase(inc), .Exp_Decrease(dec),
      .Exp_Load(load), .Exp_Load_Value(lv), .Start(start),
      .Exp_Time(exp_time), .Shutter_Open(shutter), .Busy(busy), .Done(done)
   );

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
      end
   endtask

   function automatic int clampv(input int v);
      if (v < MINV) return MINV;
      if (v > MAXV) return MAXV;
      return v;
   endfunction

   // Model: exposure described by its start edge index and length in cycles.
   int unsigned n;
   int unsigned t0;
   int unsigned len;
   bit          active;
   bit          pi;
   bit          pd;
   int          m_time;
   bit          e_shut;
   bit          e_busy;
   bit          e_done;
`ifdef EXP_AUTO_REPEAT_EN
   int unsigned hold;
`endif

   always @(posedge clk or negedge rst_n) begin : model
      bit ie, de, up, dn;
      if (!rst_n) begin
         n = 0; active = 0; m_time = DEFV; pi = 1; pd = 1;
         e_shut = 0; e_busy = 0; e_done = 0;
`ifdef EXP_AUTO_REPEAT_EN
         hold = 0;
`endif
      end else begin
         n++;
         ie = inc && !pi;
         de = dec && !pd;
`ifdef EXP_AUTO_REPEAT_EN
         if (!e_busy && (inc ^ dec) && (inc ? pi : pd)) hold++;
         else hold = 0;
         up = ie || (inc && hold >= RD*CPM && (hold - RD*CPM) % (RR*CPM) == 0);
         dn = de || (dec && hold >= RD*CPM && (hold - RD*CPM) % (RR*CPM) == 0);
`else
         up = ie;
         dn = de;
`endif
         if (!e_busy) begin
            if (start) begin
               active = 1; t0 = n; len = m_time * CPM;
            end else if (load) m_time = clampv(int'(lv));
            else if (up && !dn) m_time = (m_time < MAXV) ? m_time + 1 : MAXV;
            else if (dn && !up) m_time = (m_time > MINV) ? m_time - 1 : MINV;
         end
         pi = inc;
         pd = dec;
         e_shut = active && (n - t0) <  len;
         e_done = active && (n - t0) == len;
         e_busy = active && (n - t0) <= len;
         if (active && (n - t0) > len) active = 0;
      end
   end

   always @(negedge clk) begin
      if (checking && rst_n) begin
         chk("exp_time", int'(exp_time), m_time);
         chk("shutter", int'(shutter), int'(e_shut));
         chk("busy", int'(busy), int'(e_busy));
         chk("done", int'(done), int'(e_done));
      end
   end

   task automatic press(input bit up);
      if (up) inc = 1; else dec = 1;
      @(negedge clk);
      inc = 0; dec = 0;
      @(negedge clk);
   endtask

   task automatic do_load(input int v);
      load = 1; lv = W'(v);
      @(negedge clk);
      load = 0;
      @(negedge clk);
   endtask

   initial begin
      int sh, bz, dc, last_sh, done_at;
      inc = 1;
      repeat (3) @(negedge clk);
      rst_n = 1;
      checking = 1;
      repeat (4) @(negedge clk);
      chk("held_through_reset", int'(exp_time), 15);
      inc = 0;
      @(negedge clk);

      inc = 1;
      @(negedge clk);
      chk("one_cycle_latency", int'(exp_time), 16);
      inc = 0;
      @(negedge clk);
      press(1); press(1);
      chk("three_presses", int'(exp_time), 18);
      chk("model_three_presses", m_time, 18);

      repeat (20) press(1);
      chk("sat_max", int'(exp_time), 30);
      repeat (40) press(0);
      chk("sat_min", int'(exp_time), 2);
      chk("model_sat_min", m_time, 2);

      do_load(0);  chk("load_0", int'(exp_time), 2);
      do_load(31); chk("load_31", int'(exp_time), 30);
      do_load(7);  chk("load_7", int'(exp_time), 7);
      load = 1; lv = 10; inc = 1;
      @(negedge clk);
      load = 0; inc = 0;
      @(negedge clk);
      chk("load_beats_inc", int'(exp_time), 10);

      do_load(5);
      start = 1;
      @(negedge clk);
      start = 0;
      sh = 0; bz = 0; dc = 0; last_sh = -1; done_at = -1;
      for (int i = 0; i < 60; i++) begin
         if (shutter) begin sh++; last_sh = i; end
         if (busy) bz++;
         if (done) begin dc++; done_at = i; end
         inc   = (i == 6);
         start = (i == 9);
         @(negedge clk);
      end
      inc = 0; start = 0;
      chk("shutter_cycles", sh, 20);
      chk("busy_cycles", bz, 21);
      chk("done_pulses", dc, 1);
      chk("done_after_shutter", done_at, last_sh + 1);
      chk("frozen_time", int'(exp_time), 5);

      start = 1;
      @(negedge clk);
      start = 0;
      repeat (10) @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("abort_shutter", int'(shutter), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_time", int'(exp_time), 15);
      repeat (2) @(negedge clk);
      rst_n = 1;
      dc = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) dc++;
      end
      chk("no_done_after_abort", dc, 0);

      inc = 1;
      repeat (40) @(negedge clk);
      inc = 0;
      @(negedge clk);
`ifdef EXP_AUTO_REPEAT_EN
      chk("hold_40_cycles", int'(exp_time), 19);
`else
      chk("hold_40_cycles", int'(exp_time), 16);
`endif

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(7) == 0) inc = ~inc;
         if ($urandom_range(7) == 0) dec = ~dec;
         load  = ($urandom_range(15) == 0);
         lv    = W'($urandom_range(31));
         start = ($urandom_range(19) == 0);
         @(negedge clk);
      end
      inc = 0; dec = 0; load = 0; start = 0;
      repeat (150) @(negedge clk);
      checking = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exposure_timer_ctrl.md
Name: exposure_timer_ctrl

Overview:
- Parametrised successor to the 2-30 ms exposure-time register. It holds the exposure setting, adjusted by edge-detected Increase/Decrease keys or a direct load, and clamped to [EXP_MIN, EXP_MAX].
- It also runs the exposure itself: on Start it holds Shutter_Open high for exactly Exp_Time milliseconds, then pulses Done.
- Sits between the user-key debouncers and the sensor/shutter sequencer.

Parameters:
- W, 5: width of the exposure value in ms.
- EXP_MIN, 2: lower clamp in ms; must be at least 1.
- EXP_MAX, 30: upper clamp in ms; must be less than 2^W.
- EXP_DEFAULT, 15: value loaded at reset; EXP_MIN <= EXP_DEFAULT <= EXP_MAX.
- CLKS_PER_MS, 1: Clk cycles per millisecond; must be at least 1.
- REPEAT_DELAY_MS, 500: hold time before auto-repeat starts (optional feature only).
- REPEAT_RATE_MS, 100: auto-repeat period (optional feature only).

Ports:
- Clk  in  1  system clock, all logic on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Exp_Increase  in  1  debounced key, level.
- Exp_Decrease  in  1  debounced key, level.
- Exp_Load  in  1  one-cycle strobe: load Exp_Load_Value.
- Exp_Load_Value  in  W  value to load; clamped before storing.
- Start  in  1  request an exposure; sampled in IDLE only.
- Exp_Time  out  W  current exposure setting in ms.
- Shutter_Open  out  1  high for the exposure duration.
- Busy  out  1  high in EXPOSE and DONE.
- Done  out  1  one-cycle pulse at the end of an exposure.

Behaviour:
- Reset asserted (Reset=0), immediately and asynchronously:
  - Exp_Time=EXP_DEFAULT; Shutter_Open=0, Busy=0, Done=0.
  - FSM goes to IDLE; ms prescaler and remaining-time counter are cleared.
  - Key history registers are set to 1, so a key already held when Reset releases does not produce a step.
- Reset asserted mid-exposure aborts it. No Done is produced.
- Key edge detection: a step happens on a cycle where the key is 1 and its registered previous value is 0. Exactly one step per press.
- Adjust priority, evaluated per cycle in IDLE only:
  - Exp_Load stores clamp(Exp_Load_Value). Below EXP_MIN gives EXP_MIN; above EXP_MAX gives EXP_MAX.
  - Otherwise, an Increase edge alone: Exp_Time+1, saturating at EXP_MAX.
  - Otherwise, a Decrease edge alone: Exp_Time-1, saturating at EXP_MIN.
  - Increase and Decrease edges in the same cycle: no change.
  - Exp_Time updates the cycle after the edge (1-cycle latency).
- While Busy, Exp_Time is frozen. Loads and key edges are discarded, not queued. Edge history keeps updating, so a key held across the end of an exposure gives no step.
- FSM:
  - IDLE: if Start=1, latch Exp_Time into the remaining counter, clear the prescaler, go to EXPOSE. Any adjust request in the same cycle is dropped.
  - EXPOSE: Shutter_Open=1, Busy=1. The prescaler counts 0..CLKS_PER_MS-1. On wrap, remaining decrements. When remaining reaches 0 on a wrap, go to DONE.
  - DONE: Shutter_Open=0, Busy=1, Done=1 for one cycle, then IDLE.
- Timing: Shutter_Open is high for exactly Exp_Time*CLKS_PER_MS cycles. Done asserts the cycle after Shutter_Open falls. The first cycle Start can be accepted again is the cycle after Done.
- Start outside IDLE is ignored.
- Internal counters use W bits for remaining and clog2(CLKS_PER_MS) bits, minimum 1, for the prescaler. No arithmetic overflow is possible given the parameter rules.

Optional Feature:
- Macro: EXP_AUTO_REPEAT_EN.
- When defined, applies in IDLE only:
  - A key held continuously (the other key low) for REPEAT_DELAY_MS produces an extra step, then one more every REPEAT_RATE_MS.
  - This uses a ms-based hold counter that is cleared on release, on Busy, or if both keys are high.
  - Saturation rules are the same as for single steps.
- When not defined: one step per press only, and no hold counter is synthesised.

Test Plan:
- Release reset with Exp_Increase held at 1 -> Exp_Time stays 15. Release the key, then 3 presses -> Exp_Time=18, each update 1 cycle after its edge.
- 20 Increase presses from 15 -> saturates at 30. Then 40 Decrease presses -> saturates at 2, never 1 or 0.
- Exp_Load with Exp_Load_Value=0 -> 2; =31 -> 30; =7 -> 7. Exp_Load with an Increase edge in the same cycle -> load wins.
- CLKS_PER_MS=4, Exp_Time=5, Start pulse -> Shutter_Open high for exactly 20 cycles, Done 1 cycle later, Busy covers 21 cycles. Increase press and Start mid-exposure are ignored; Exp_Time stays 5.
- Reset asserted at cycle 10 of the exposure -> Shutter_Open and Busy drop immediately, no Done, Exp_Time=15.
- With EXP_AUTO_REPEAT_EN, CLKS_PER_MS=1, Increase held 800 ms from 15 -> steps at press, 500 ms, 600 ms, 700 ms, 800 ms, giving Exp_Time=20. Without the macro -> Exp_Time=16.
